vector_mem_mover: RTL

//  Client-side engine for the 4x64-bit vector register file. Moves one 64-bit vector between

---
 rtl/vector_mem_mover_pkg.sv | 29 ++
 rtl/vector_mem_mover_shifter.sv | 37 +++
 rtl/vector_mem_mover.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/vector_mem_mover_pkg.sv
// Shared definitions for the vector memory mover and the control unit that drives it.
// Contents: FSM state encoding, vector geometry constants, LOAD/STORE opcode values,
//           and a byte-counter increment helper.
package vector_mem_mover_pkg;

  localparam int VEC_BYTES  = 8;
  localparam int VREG_COUNT = 4;
  localparam int VREG_W     = $clog2(VREG_COUNT);

  // Opcode carried on cmd_store; the control unit uses the same values.
  localparam logic OP_LOAD  = 1'b0;
  localparam logic OP_STORE = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD_ISSUE,
    S_LD_DRAIN,
    S_LD_WB,
    S_ST_RD,
    S_ST_WR,
    S_DONE
  } state_t;

  // 3-bit byte index; wraps 7 -> 0 so every phase leaves the counter at zero.
  function automatic logic [2:0] next_byte(input logic [2:0] k);
    return k + 3'd1;
  endfunction

endpackage

// File: rtl/vector_mem_mover_shifter.sv
// vec_byte_shifter: byte-wide shift register holding one vector.
// Ports: clk/rst_n (sync active-low); load + load_vec parallel-load a whole vector;
//        shift moves every byte down one slot, shift_in enters at the top byte;
//        byte_out is the lowest byte, vec_out the whole register.
module vec_byte_shifter
  import vector_mem_mover_pkg::*;
#(
  parameter int NBYTES = VEC_BYTES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [8*NBYTES-1:0]   load_vec,
  input  logic                  shift,
  input  logic [7:0]            shift_in,
  output logic [7:0]            byte_out,
  output logic [8*NBYTES-1:0]   vec_out
);

  logic [8*NBYTES-1:0] data;

  // Shifting toward bit 0 serves both directions: LOAD feeds byte k in at the top so
  // byte 0 ends at [7:0] after NBYTES shifts; STORE emits byte 0 first from [7:0].
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data <= '0;
    end else if (load) begin
      data <= load_vec;
    end else if (shift) begin
      data <= {shift_in, data[8*NBYTES-1:8]};
    end
  end

  assign byte_out = data[7:0];
  assign vec_out  = data;

endmodule

// File: rtl/vector_mem_mover.sv
// vector_mem_mover: moves one 64-bit vector between byte-wide memory and a vector
// register. LOAD packs 8 little-endian bytes into a register, STORE unpacks a register.
// Ports: cmd_* request (valid/ready, accepted only in IDLE), busy/done status,
//        mem_* byte memory (addr/rdata/wdata/wren), vr_* register file (dir/value_in/
//        wren/value_out). Clock clk, synchronous active-low rst_n.
module vector_mem_mover
  import vector_mem_mover_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int MEM_RD_LAT = 1,
  parameter int VR_RD_LAT  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_store,
  input  logic [VREG_W-1:0] cmd_vreg,
  input  logic [ADDR_W-1:0] cmd_addr,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        mem_wdata,
  output logic              mem_wren,
  output logic [VREG_W-1:0] vr_dir,
  output logic [63:0]       vr_value_in,
  output logic              vr_wren,
  input  logic [63:0]       vr_value_out
);

  localparam int              RD_CW   = $clog2(VR_RD_LAT + 1);
  localparam logic [RD_CW-1:0] RD_LAST = RD_CW'(VR_RD_LAT - 1);

  state_t                state;
  state_t                state_nxt;

  logic [VREG_W-1:0]     vreg_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [2:0]            byte_cnt;   // issue index (LOAD) / write index (STORE)
  logic [2:0]            cap_cnt;    // index of the next returning read byte
  logic [RD_CW-1:0]      rd_cnt;     // register-file read wait
  logic [MEM_RD_LAT-1:0] vld_pipe;   // tracks in-flight memory reads
  logic [63:0]           packed_q;   // last written vector, held on vr_value_in

  logic                  accept;
  logic                  cap_fire;
  logic                  rd_last;
  logic                  sh_load;
  logic                  sh_shift;
  logic [7:0]            sh_in;
  logic [7:0]            sh_byte;
  logic [63:0]           sh_vec;

  assign accept   = cmd_valid && (state == S_IDLE);
  assign cap_fire = vld_pipe[MEM_RD_LAT-1];
  assign rd_last  = (rd_cnt == RD_LAST);

  // ---------------------------------------------------------------- state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          state_nxt = (cmd_store == OP_STORE) ? S_ST_RD : S_LD_ISSUE;
        end
      end
      S_LD_ISSUE: begin
        if (byte_cnt == 3'd7) state_nxt = S_LD_DRAIN;
      end
      S_LD_DRAIN: begin
        // The final byte is always in flight here, since reads take at least a cycle.
        if (cap_fire && (cap_cnt == 3'd7)) state_nxt = S_LD_WB;
      end
      S_LD_WB: state_nxt = S_DONE;
      S_ST_RD: begin
        if (rd_last) state_nxt = S_ST_WR;
      end
      S_ST_WR: begin
        if (byte_cnt == 3'd7) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- outputs
  always_comb begin
    cmd_ready   = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    mem_wren    = 1'b0;
    vr_wren     = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    vr_value_in = packed_q;
    case (state)
      S_IDLE: cmd_ready = 1'b1;
      S_LD_ISSUE: begin
        busy     = 1'b1;
        mem_addr = addr_q + ADDR_W'(byte_cnt);
      end
      S_LD_DRAIN: busy = 1'b1;
      S_LD_WB: begin
        busy        = 1'b1;
        vr_wren     = 1'b1;
        vr_value_in = sh_vec;
      end
      S_ST_RD: busy = 1'b1;
      S_ST_WR: begin
        busy      = 1'b1;
        mem_wren  = 1'b1;
        mem_addr  = addr_q + ADDR_W'(byte_cnt);
        mem_wdata = sh_byte;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // The register-file select follows the latched vreg and keeps it after completion.
  assign vr_dir = vreg_q;

  // ---------------------------------------------------------------- datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vreg_q   <= '0;
      addr_q   <= '0;
      byte_cnt <= '0;
      cap_cnt  <= '0;
      rd_cnt   <= '0;
      vld_pipe <= '0;
      packed_q <= '0;
    end else begin
      if (accept) begin
        vreg_q   <= cmd_vreg;
        addr_q   <= cmd_addr;
        byte_cnt <= '0;
        cap_cnt  <= '0;
        rd_cnt   <= '0;
      end
      if ((state == S_LD_ISSUE) || (state == S_ST_WR)) begin
        byte_cnt <= next_byte(byte_cnt);
      end
      if (cap_fire) begin
        cap_cnt <= next_byte(cap_cnt);
      end
      if (state == S_ST_RD) begin
        rd_cnt <= rd_cnt + RD_CW'(1);
      end
      if (state == S_LD_WB) begin
        packed_q <= sh_vec;
      end
      // A read issued in cycle c returns MEM_RD_LAT cycles later; the top bit marks
      // the cycle in which mem_rdata carries that byte.
      vld_pipe[0] <= (state == S_LD_ISSUE);
      for (int i = 1; i < MEM_RD_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
      end
    end
  end

  // ---------------------------------------------------------------- byte shifter
  assign sh_load  = (state == S_ST_RD) && rd_last;
  assign sh_shift = cap_fire || (state == S_ST_WR);
  assign sh_in    = cap_fire ? mem_rdata : 8'h00;

  vec_byte_shifter #(
    .NBYTES (VEC_BYTES)
  ) u_shifter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (sh_load),
    .load_vec (vr_value_out),
    .shift    (sh_shift),
    .shift_in (sh_in),
    .byte_out (sh_byte),
    .vec_out  (sh_vec)
  );

endmodule
